// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Parameterised serial pattern detector. A Moore FSM with states S0..SN,
//   where Sk means the last k sampled bits equal the first k pattern bits.
//   The transition table is derived at elaboration using the KMP rule (longest
//   suffix of the matched prefix plus the new bit that is also a pattern prefix).
//
// Parameters
//   N       : pattern length in bits (2..16)
//   PATTERN : target sequence, N bits wide, PATTERN[N-1] is received first
//   CNT_W   : detection counter width (1..16)
//
// Ports
//   clk     : in  - clock, rising edge
//   rst     : in  - asynchronous active-high reset
//   x       : in  - serial data bit, sampled when en=1
//   en      : in  - sample enable; 0 holds all state
//   ovl     : in  - 1 = overlapping detection, 0 = non-overlapping
//   z       : out - Moore detect flag, high while state==SN
//   det_cnt : out - saturating detection count (only with SEQ_DETECT_CNT_EN)
//
// Build option
//   SEQ_DETECT_CNT_EN : when defined, compiles in det_cnt and its counter.
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int N       = 7,
  parameter     PATTERN = 7'b1111001,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             ovl,
`ifdef SEQ_DETECT_CNT_EN
  output logic [CNT_W-1:0] det_cnt,
`endif
  output logic             z
);

  // Parameter legality checks, reported during elaboration.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detect_param: N=%0d outside legal range 2..16", N);
  end
  if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W=%0d outside legal range 1..16", CNT_W);
  end
  if ($bits(PATTERN) != N) begin : g_bad_pattern
    $error("seq_detect_param: PATTERN is %0d bits wide, expected N=%0d", $bits(PATTERN), N);
  end

  localparam int SW      = $clog2(N + 1);
  localparam int TBL_LEN = 2 ** SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t S0 = '0;
  localparam state_t SN = state_t'(N);

  // Next state from Sk on input b: the longest l (1..N) such that the last l
  // symbols of (first k pattern bits, b) equal the first l pattern bits.
  // Pattern symbol i (0 = first received) is PATTERN[N-1-i].
  function automatic state_t kmp_next(input int k, input logic b);
    int   best;
    int   j;
    logic ok;
    logic sj;
    best = 0;
    for (int l = 1; l <= N; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++) begin
          j = k + 1 - l + i;
          if (j == k) sj = b;
          else        sj = PATTERN[N-1-j];
          if (sj != PATTERN[N-1-i]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return state_t'(best);
  endfunction

  // Constant transition tables, one per input value. Entries beyond SN are
  // unreachable and parked at S0 so every state encoding has a defined target.
  state_t nxt0_tbl [TBL_LEN];
  state_t nxt1_tbl [TBL_LEN];

  for (genvar gi = 0; gi < TBL_LEN; gi++) begin : g_tbl
    if (gi <= N) begin : g_live
      localparam state_t NXT0 = kmp_next(gi, 1'b0);
      localparam state_t NXT1 = kmp_next(gi, 1'b1);
      assign nxt0_tbl[gi] = NXT0;
      assign nxt1_tbl[gi] = NXT1;
    end else begin : g_unused
      assign nxt0_tbl[gi] = S0;
      assign nxt1_tbl[gi] = S0;
    end
  end

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    z       = 1'b0;
    if (en) begin
      // Non-overlapping mode restarts the search as if from S0.
      if (state_q == SN && !ovl) state_d = x ? nxt1_tbl[S0] : nxt0_tbl[S0];
      else                       state_d = x ? nxt1_tbl[state_q] : nxt0_tbl[state_q];
    end
    z = (state_q == SN);
  end

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Count entries into SN; stop at all-ones instead of wrapping.
    if (en && state_d == SN && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign det_cnt = cnt_q;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter N, default 7: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 7'b1111001: target sequence, N bits wide, PATTERN[N-1] received first.
REQ-003 SHALL have parameter CNT_W, default 8: detection counter width, legal range 1..16.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port x, input, 1 bit: serial data bit, sampled when en=1.
REQ-007 SHALL have port en, input, 1 bit: sample enable; 0 means hold all state.
REQ-008 SHALL have port ovl, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-009 SHALL have port z, output, 1 bit: Moore detect flag, a function of state only.
REQ-010 SHALL have port det_cnt, output, CNT_W bits: saturating detection count; present only with SEQ_DETECT_CNT_EN.

Function
REQ-011 SHALL implement a Moore FSM with states S0..SN, where Sk means the last k sampled bits equal the first k pattern bits.
REQ-012 SHALL, when en=1 in any state Sk with k<N, move to the length of the longest suffix of (matched prefix, x) that is also a prefix of PATTERN (KMP transition).
REQ-013 SHALL, in state SN with en=1 and ovl=1, compute the next state as in REQ-012 from the full pattern plus x, so overlapping matches are kept.
REQ-014 SHALL, in state SN with en=1 and ovl=0, compute the next state as if from S0 with input x, discarding all overlap.
REQ-015 SHALL drive z=1 exactly when state==SN; z asserts in the cycle after the edge that sampled the last pattern bit.
REQ-016 SHALL hold z high for one cycle per detection when en stays 1; while en=0, state and z SHALL hold.
REQ-017 SHALL sample ovl only on edges where state==SN and en=1; changing ovl at other times SHALL have no effect.
REQ-018 SHALL derive all transitions from the parameters at elaboration; a hand-coded per-pattern table is prohibited.
REQ-019 SHALL tolerate self-overlapping patterns (e.g. 1010, 1111) and patterns with no self-overlap without special cases.
REQ-020 SHALL flag illegal N, CNT_W, or PATTERN width at elaboration via a simulation-time error message.

Reset
REQ-021 SHALL, while rst=1, force state=S0, z=0, and det_cnt=0 immediately, regardless of clk.
REQ-022 SHALL discard any partial match on reset mid-stream; after reset is released, detection restarts from S0 on the first enabled edge.

Configuration
REQ-023 SHALL use the macro SEQ_DETECT_CNT_EN to compile the detection counter in or out.
REQ-024 SHALL, with SEQ_DETECT_CNT_EN defined, increment det_cnt by 1 on every edge whose next state is SN and en=1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 SHALL, with SEQ_DETECT_CNT_EN undefined, omit the det_cnt port and its counter logic; FSM and z behaviour SHALL be identical in both builds.

Verification
REQ-026 SHALL cover: defaults, ovl=1, en=1, stream 1111001 -> z=1 in the cycle after the 7th bit, z=0 before that.
REQ-027 SHALL cover: defaults, ovl=1, stream 1111001111001 (13 bits) -> z pulses after bit 7 and after bit 13; det_cnt=2.
REQ-028 SHALL cover: same 13-bit stream with ovl=0 -> z pulses only after bit 7; det_cnt=1.
REQ-029 SHALL cover: N=4, PATTERN=4'b1010, ovl=1, stream 1010101 -> z pulses after bits 4 and 6; with ovl=0, only after bit 4.
REQ-030 SHALL cover: defaults, drive 111100, assert rst asynchronously mid-cycle, release, then 1111001 -> z, state, and det_cnt clear at once; single detection after bit 7 of the new stream.
REQ-031 SHALL cover: CNT_W=2, 5 back-to-back detections -> det_cnt saturates at 3; en=0 for 3 cycles while in SN -> z held at 1 and det_cnt unchanged.
